usb_devep_ctrl: RTL and testbench

Endpoint controller for the USB device transaction layer. Sits between `usb_devtrsac` and up to 16 endpoint buffers and serves tokens reported by the transaction layer. For each token it selects the addressed endpoint, decides the handshake (ACK/NAK/STALL/none), and supplies the data toggle. It grants the datapath to that endpoint for one transaction and keeps per-endpoint toggle and stall state.

---
 rtl/usb_dev_pkg.sv | 26 ++
 rtl/usb_devep_reg.sv | 58 +++++
 rtl/usb_devep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_usb_devep_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_dev_pkg.sv
// Shared codes and constants for the USB device endpoint controller.
package usb_dev_pkg;

  localparam int unsigned EP_NUM_MAX = 16;
  localparam int unsigned EP_W       = 4;

  // Token type codes reported by the transaction layer
  localparam logic [1:0] TT_OUT   = 2'b00;
  localparam logic [1:0] TT_IN    = 2'b01;
  localparam logic [1:0] TT_SETUP = 2'b10;
  localparam logic [1:0] TT_RSVD  = 2'b11;

  // Handshake codes returned to the transaction layer
  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;
  localparam logic [1:0] HS_NONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2,
    ST_BUSY   = 2'd3
  } state_t;

endpackage

// File: rtl/usb_devep_reg.sv
// Per-endpoint data toggle and stall flag.
// Stall flop exists only when USB_DEVEP_CTRL_STALL_EN is defined.
module usb_devep_reg (
  input  logic clk,
  input  logic rst,
  input  logic stall_set_i,
  input  logic stall_clr_i,
  input  logic setup_clr_i,
  input  logic flip_i,
  input  logic set_one_i,
  input  logic toggle_rst_i,
  output logic toggle_o,
  output logic stall_o
);

  logic tgl_q, tgl_d;

  // Toggle next value: forced reset beats a completion write
  always_comb begin
    tgl_d = tgl_q;
    if (toggle_rst_i)   tgl_d = 1'b0;
    else if (set_one_i) tgl_d = 1'b1;
    else if (flip_i)    tgl_d = ~tgl_q;
  end

  // Toggle register
  always_ff @(posedge clk) begin
    if (rst) tgl_q <= 1'b0;
    else     tgl_q <= tgl_d;
  end

  assign toggle_o = tgl_q;

`ifdef USB_DEVEP_CTRL_STALL_EN
  logic stall_q, stall_d;

  // Stall next value: SETUP clear beats set, set beats clear
  always_comb begin
    stall_d = stall_q;
    if (setup_clr_i)      stall_d = 1'b0;
    else if (stall_set_i) stall_d = 1'b1;
    else if (stall_clr_i) stall_d = 1'b0;
  end

  // Stall register
  always_ff @(posedge clk) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= stall_d;
  end

  assign stall_o = stall_q;
`else
  logic unused_stall;
  assign unused_stall = ^{stall_set_i, stall_clr_i, setup_clr_i};
  assign stall_o      = 1'b0;
`endif

endmodule

// File: rtl/usb_devep_ctrl.sv
// Endpoint controller: serves tokens, picks handshake and data toggle,
// grants the datapath for one transaction, keeps toggle/stall state.
// Optional macro USB_DEVEP_CTRL_STALL_EN adds stall registers and STALL.
module usb_devep_ctrl
  import usb_dev_pkg::*;
#(
  parameter int unsigned EP_NUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trsac_req,
  input  logic [1:0]        trsac_type,
  input  logic [3:0]        trsac_ep,
  output logic              trsac_ack,
  output logic [1:0]        trsac_hs,
  output logic              trsac_toggle,
  input  logic              trsac_done,
  input  logic              trsac_ok,
  input  logic              trsac_pid_tgl,
  input  logic [EP_NUM-1:0] ep_enable,
  input  logic [EP_NUM-1:0] ep_ready,
  input  logic [EP_NUM-1:0] ep_stall_set,
  input  logic [EP_NUM-1:0] ep_stall_clr,
  input  logic [EP_NUM-1:0] ep_toggle_rst,
  output logic [EP_NUM-1:0] ep_sel,
  output logic [EP_NUM-1:0] ep_commit,
  output logic [EP_NUM-1:0] ep_setup,
  output logic [EP_NUM-1:0] ep_stalled
);

  state_t            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [EP_W-1:0]   ep_q, ep_d;
  logic [1:0]        hs_q, hs_d;
  logic              tog_q, tog_d;
  logic              ack_q, ack_d;
  logic [EP_NUM-1:0] sel_q, sel_d;
  logic [EP_NUM-1:0] commit_q, commit_d;
  logic [EP_NUM-1:0] setup_q, setup_d;
  logic [EP_NUM-1:0] flip_c, set_one_c, setup_clr_c, tgl_c, stall_c;
  logic [EP_NUM_MAX-1:0] en16, rdy16, stl16, tgl16, onehot16;

  // Zero-pad per-endpoint vectors so any 4-bit endpoint number indexes safely
  assign en16     = EP_NUM_MAX'(ep_enable);
  assign rdy16    = EP_NUM_MAX'(ep_ready);
  assign stl16    = EP_NUM_MAX'(stall_c);
  assign tgl16    = EP_NUM_MAX'(tgl_c);
  assign onehot16 = EP_NUM_MAX'(1) << ep_q;

  // Next-state, handshake decision and completion strobes
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    ep_d        = ep_q;
    hs_d        = hs_q;
    tog_d       = tog_q;
    ack_d       = 1'b0;
    sel_d       = sel_q;
    commit_d    = '0;
    setup_d     = '0;
    flip_c      = '0;
    set_one_c   = '0;
    setup_clr_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (trsac_req) begin
          type_d  = trsac_type;
          ep_d    = trsac_ep;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        ack_d   = 1'b1;
        tog_d   = 1'b0;
        state_d = ST_RESP;
        if ((32'(ep_q) >= EP_NUM) || !en16[ep_q] || (type_q == TT_RSVD)) begin
          hs_d = HS_NONE;
        end else if (type_q == TT_SETUP) begin
          hs_d = (ep_q == EP_W'(0)) ? HS_ACK : HS_NONE;
        end else if (stl16[ep_q]) begin
          hs_d = HS_STALL;
        end else if (!rdy16[ep_q]) begin
          hs_d = HS_NAK;
        end else begin
          hs_d  = HS_ACK;
          tog_d = tgl16[ep_q];
        end
      end
      ST_RESP: begin
        if (hs_q == HS_ACK) begin
          sel_d   = onehot16[EP_NUM-1:0];
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (trsac_done) begin
          sel_d   = '0;
          state_d = ST_IDLE;
          case (type_q)
            TT_IN: begin
              if (trsac_ok) begin
                commit_d = onehot16[EP_NUM-1:0];
                flip_c   = onehot16[EP_NUM-1:0];
              end
            end
            TT_OUT: begin
              // A PID that does not match the expected toggle is a retransmit
              if (trsac_ok && (trsac_pid_tgl == tog_q)) begin
                commit_d = onehot16[EP_NUM-1:0];
                flip_c   = onehot16[EP_NUM-1:0];
              end
            end
            TT_SETUP: begin
              if (trsac_ok) begin
                setup_d[0]     = 1'b1;
                set_one_c[0]   = 1'b1;
                setup_clr_c[0] = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      type_q   <= TT_OUT;
      ep_q     <= '0;
      hs_q     <= HS_ACK;
      tog_q    <= 1'b0;
      ack_q    <= 1'b0;
      sel_q    <= '0;
      commit_q <= '0;
      setup_q  <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      ep_q     <= ep_d;
      hs_q     <= hs_d;
      tog_q    <= tog_d;
      ack_q    <= ack_d;
      sel_q    <= sel_d;
      commit_q <= commit_d;
      setup_q  <= setup_d;
    end
  end

  // Per-endpoint toggle/stall state
  for (genvar i = 0; i < EP_NUM; i++) begin : g_ep
    usb_devep_reg u_reg (
      .clk          (clk),
      .rst          (rst),
      .stall_set_i  (ep_stall_set[i]),
      .stall_clr_i  (ep_stall_clr[i]),
      .setup_clr_i  (setup_clr_c[i]),
      .flip_i       (flip_c[i]),
      .set_one_i    (set_one_c[i]),
      .toggle_rst_i (ep_toggle_rst[i]),
      .toggle_o     (tgl_c[i]),
      .stall_o      (stall_c[i])
    );
  end

  assign trsac_ack    = ack_q;
  assign trsac_hs     = hs_q;
  assign trsac_toggle = tog_q;
  assign ep_sel       = sel_q;
  assign ep_commit    = commit_q;
  assign ep_setup     = setup_q;
  assign ep_stalled   = stall_c;

endmodule

// File: tb/tb_usb_devep_ctrl.sv
// Self-checking bench for usb_devep_ctrl: transaction-level model plus
// per-cycle output compare, directed scenarios then randomized tokens.
module tb_usb_devep_ctrl;
  import usb_dev_pkg::*;

  localparam int unsigned EPN = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           trsac_req, trsac_ack, trsac_toggle, trsac_done, trsac_ok, trsac_pid_tgl;
  logic [1:0]     trsac_type, trsac_hs;
  logic [3:0]     trsac_ep;
  logic [EPN-1:0] ep_enable, ep_ready, ep_stall_set, ep_stall_clr, ep_toggle_rst;
  logic [EPN-1:0] ep_sel, ep_commit, ep_setup, ep_stalled;

  always #5 clk = ~clk;

  usb_devep_ctrl #(.EP_NUM(EPN)) dut (
    .clk(clk), .rst(rst),
    .trsac_req(trsac_req), .trsac_type(trsac_type), .trsac_ep(trsac_ep),
    .trsac_ack(trsac_ack), .trsac_hs(trsac_hs), .trsac_toggle(trsac_toggle),
    .trsac_done(trsac_done), .trsac_ok(trsac_ok), .trsac_pid_tgl(trsac_pid_tgl),
    .ep_enable(ep_enable), .ep_ready(ep_ready),
    .ep_stall_set(ep_stall_set), .ep_stall_clr(ep_stall_clr), .ep_toggle_rst(ep_toggle_rst),
    .ep_sel(ep_sel), .ep_commit(ep_commit), .ep_setup(ep_setup), .ep_stalled(ep_stalled)
  );

  int checks = 0;
  int failures = 0;

  // Model: visible per-endpoint state and expected outputs for the current cycle
  bit             m_tog [16];
  bit             m_stl [16];
  logic           exp_ack;
  logic [1:0]     exp_hs;
  logic           exp_tog;
  logic [EPN-1:0] exp_sel, exp_commit, exp_setup;
  logic [EPN-1:0] cf_flip, cf_one, cf_sclr;
  bit             chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [EPN-1:0] onehot(input logic [3:0] e);
    logic [EPN-1:0] v;
    for (int i = 0; i < int'(EPN); i++) v[i] = (int'(e) == i);
    return v;
  endfunction

  // Handshake/toggle a token must get, from the endpoint rules
  function automatic void resp(input logic [1:0] t, input logic [3:0] e,
                               output logic [1:0] hs, output logic tg);
    logic [15:0] en16, rd16;
    en16 = 16'(ep_enable);
    rd16 = 16'(ep_ready);
    hs = HS_NONE;
    tg = 1'b0;
    if (32'(e) >= EPN || !en16[e] || t == TT_RSVD) hs = HS_NONE;
    else if (t == TT_SETUP) begin
      if (e == 4'd0) hs = HS_ACK;
    end
    else if (m_stl[e]) hs = HS_STALL;
    else if (!rd16[e]) hs = HS_NAK;
    else begin
      hs = HS_ACK;
      tg = m_tog[e];
    end
  endfunction

  // Advance one clock; fold the pulses seen at this edge into the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_tog[i] = 1'b0;
        m_stl[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(EPN); i++) begin
`ifdef USB_DEVEP_CTRL_STALL_EN
        if (cf_sclr[i])           m_stl[i] = 1'b0;
        else if (ep_stall_set[i]) m_stl[i] = 1'b1;
        else if (ep_stall_clr[i]) m_stl[i] = 1'b0;
`endif
        if (ep_toggle_rst[i]) m_tog[i] = 1'b0;
        else if (cf_one[i])   m_tog[i] = 1'b1;
        else if (cf_flip[i])  m_tog[i] = ~m_tog[i];
      end
    end
    cf_flip = '0;
    cf_one  = '0;
    cf_sclr = '0;
    #1;
  endtask

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [EPN-1:0] sv;
      for (int i = 0; i < int'(EPN); i++) sv[i] = m_stl[i];
      check("ack", 16'(trsac_ack), 16'(exp_ack));
      if (exp_ack) begin
        check("hs", 16'(trsac_hs), 16'(exp_hs));
        if (exp_hs == HS_ACK) check("toggle", 16'(trsac_toggle), 16'(exp_tog));
      end
      check("ep_sel", 16'(ep_sel), 16'(exp_sel));
      check("ep_commit", 16'(ep_commit), 16'(exp_commit));
      check("ep_setup", 16'(ep_setup), 16'(exp_setup));
      check("ep_stalled", 16'(ep_stalled), 16'(sv));
    end
  end

  // Idle gap: one cycle of stall/toggle pulses, then a quiet cycle with a stray done
  task automatic gap(input logic [EPN-1:0] ss, input logic [EPN-1:0] sc, input logic [EPN-1:0] tr);
    ep_stall_set  = ss;
    ep_stall_clr  = sc;
    ep_toggle_rst = tr;
    tick();
    ep_stall_set  = '0;
    ep_stall_clr  = '0;
    ep_toggle_rst = '0;
    trsac_done    = 1'($urandom);
    trsac_ok      = 1'b1;
    tick();
    trsac_done    = 1'b0;
  endtask

  // One token from request through completion
  task automatic do_txn(input logic [1:0] t, input logic [3:0] e, input logic ok, input logic pid,
                        input int nwait, input bit conflict, input bit rst_busy,
                        output logic [1:0] hs, output logic tg,
                        output logic [EPN-1:0] cm, output logic [EPN-1:0] su);
    cm = '0;
    su = '0;
    resp(t, e, hs, tg);
    trsac_req  = 1'b1;
    trsac_type = t;
    trsac_ep   = e;
    tick();
    trsac_req  = 1'b0;
    trsac_done = 1'($urandom);
    trsac_ok   = 1'($urandom);
    tick();
    trsac_done = 1'b0;
    exp_ack    = 1'b1;
    exp_hs     = hs;
    exp_tog    = tg;
    if ($urandom_range(0, 3) == 0) begin
      trsac_req  = 1'b1;
      trsac_type = 2'($urandom);
      trsac_ep   = 4'($urandom);
    end
    tick();
    trsac_req = 1'b0;
    exp_ack   = 1'b0;
    if (hs == HS_ACK) begin
      exp_sel = onehot(e);
      for (int i = 0; i < nwait; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          trsac_req  = 1'b1;
          trsac_type = 2'($urandom);
          trsac_ep   = 4'($urandom);
        end
        tick();
        trsac_req = 1'b0;
      end
      if (rst_busy) begin
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        exp_sel       = '0;
        trsac_done    = 1'b1;
        trsac_ok      = 1'b1;
        trsac_pid_tgl = tg;
        tick();
        trsac_done = 1'b0;
      end else begin
        trsac_done    = 1'b1;
        trsac_ok      = ok;
        trsac_pid_tgl = pid;
        if (conflict) begin
          ep_stall_set  = EPN'($urandom);
          ep_stall_clr  = EPN'($urandom);
          ep_toggle_rst = EPN'($urandom);
        end
        if (t == TT_IN && ok) cm = onehot(e);
        if (t == TT_OUT && ok && pid == tg) cm = onehot(e);
        if (t == TT_SETUP && ok) begin
          su[0]      = 1'b1;
          cf_one[0]  = 1'b1;
          cf_sclr[0] = 1'b1;
        end
        cf_flip = cm;
        tick();
        trsac_done    = 1'b0;
        ep_stall_set  = '0;
        ep_stall_clr  = '0;
        ep_toggle_rst = '0;
        exp_sel       = '0;
        exp_commit    = cm;
        exp_setup     = su;
        tick();
        exp_commit = '0;
        exp_setup  = '0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired=1 required=0");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]     hs;
    logic           tg;
    logic [EPN-1:0] cm, su;
    rst = 1'b1;
    trsac_req = 1'b0; trsac_type = TT_OUT; trsac_ep = 4'd0;
    trsac_done = 1'b0; trsac_ok = 1'b0; trsac_pid_tgl = 1'b0;
    ep_enable = '0; ep_ready = '0;
    ep_stall_set = '0; ep_stall_clr = '0; ep_toggle_rst = '0;
    exp_ack = 1'b0; exp_hs = HS_ACK; exp_tog = 1'b0;
    exp_sel = '0; exp_commit = '0; exp_setup = '0;
    cf_flip = '0; cf_one = '0; cf_sclr = '0;
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    ep_enable = '1;
    ep_ready  = '1;
    gap('0, '0, '0);

    // IN ep1: ACK DATA0, commit, next IN uses DATA1
    do_txn(TT_IN, 4'd1, 1'b1, 1'b0, 1, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_in_hs", 16'(hs), 16'(HS_ACK));
    check("pin_in_tog", 16'(tg), 16'd0);
    check("pin_in_commit", 16'(cm), 16'b0010);
    gap('0, '0, '0);
    do_txn(TT_IN, 4'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_in2_tog", 16'(tg), 16'd1);
    gap('0, '0, '0);

    // OUT ep2 with PID mismatch: duplicate, toggle stays DATA0
    do_txn(TT_OUT, 4'd2, 1'b1, 1'b1, 2, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_out_tog", 16'(tg), 16'd0);
    check("pin_out_commit", 16'(cm), 16'd0);
    gap('0, '0, '0);
    do_txn(TT_OUT, 4'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_out2_tog", 16'(tg), 16'd0);

    // Not ready gives NAK
    ep_ready = 4'b1101;
    gap('0, '0, '0);
    do_txn(TT_IN, 4'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_nak_hs", 16'(hs), 16'(HS_NAK));
    ep_ready = '1;

    // Stalled ep1, then SETUP on stalled ep0
    gap(4'b0010, '0, '0);
    do_txn(TT_IN, 4'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
`ifdef USB_DEVEP_CTRL_STALL_EN
    check("pin_stall_hs", 16'(hs), 16'(HS_STALL));
`else
    check("pin_stall_hs", 16'(hs), 16'(HS_ACK));
`endif
    gap(4'b0001, '0, '0);
    do_txn(TT_SETUP, 4'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_setup_hs", 16'(hs), 16'(HS_ACK));
    check("pin_setup_tog", 16'(tg), 16'd0);
    check("pin_setup_vec", 16'(su), 16'b0001);
    check("pin_setup_m_tog", 16'(m_tog[0]), 16'd1);
`ifdef USB_DEVEP_CTRL_STALL_EN
    check("pin_setup_m_stl", 16'(m_stl[0]), 16'd0);
`endif
    gap('0, '0, '0);
    do_txn(TT_IN, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_ep0_tog", 16'(tg), 16'd1);
    gap('0, 4'b0010, '0);

    // Invalid tokens get no response
    do_txn(TT_IN, 4'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_ep7_hs", 16'(hs), 16'(HS_NONE));
    gap('0, '0, '0);
    do_txn(TT_SETUP, 4'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_setup1_hs", 16'(hs), 16'(HS_NONE));
    gap('0, '0, '0);
    do_txn(TT_RSVD, 4'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
    check("pin_rsvd_hs", 16'(hs), 16'(HS_NONE));
    gap('0, '0, '0);

    // Reset during BUSY, then every toggle reads DATA0
    do_txn(TT_IN, 4'd2, 1'b1, 1'b0, 1, 1'b0, 1'b1, hs, tg, cm, su);
    gap('0, '0, '0);
    for (int e = 0; e < int'(EPN); e++) begin
      do_txn(TT_IN, 4'(e), 1'b0, 1'b0, 0, 1'b0, 1'b0, hs, tg, cm, su);
      check("pin_rst_tog", 16'(tg), 16'd0);
      gap('0, '0, '0);
    end

    // Randomized tokens
    for (int n = 0; n < 400; n++) begin
      logic [1:0] t;
      logic [3:0] e;
      ep_enable = ~(EPN'($urandom) & EPN'($urandom) & EPN'($urandom));
      ep_ready  = ~(EPN'($urandom) & EPN'($urandom));
      gap(EPN'($urandom) & EPN'($urandom) & EPN'($urandom),
          EPN'($urandom) & EPN'($urandom),
          EPN'($urandom) & EPN'($urandom) & EPN'($urandom));
      t = 2'($urandom);
      e = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      do_txn(t, e, ($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), 1'b0, hs, tg, cm, su);
    end

    repeat (3) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
